// File: rtl/viterbi_traceback.sv
`default_nettype none
// viterbi_traceback -- 16-state survivor-memory traceback with LIFO bit reordering (rev 1.0).
// Define VTB_FINAL_STATE_EN to add the final_state_o / final_vld_o outputs.
module viterbi_traceback #(
  parameter int TB_DEPTH = 64,
  parameter int DEC_LEN  = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [3:0]  start_state_i,
  input  logic [11:0] end_addr_i,
  output logic        busy_o,
  output logic        rd_en_o,
  output logic [11:0] addr_o,
  input  logic        mem_stall_i,
  input  logic [23:0] rdata_i,
  output logic        dout_o,
  output logic        dout_vld_o,
  input  logic        dout_rdy_i,
`ifdef VTB_FINAL_STATE_EN
  output logic [3:0]  final_state_o,
  output logic        final_vld_o,
`endif
  output logic        done_o
);

  localparam int            TOTAL   = TB_DEPTH + DEC_LEN;
  localparam int            CW      = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] LAST_RD = CW'(TOTAL - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(TB_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACE = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t        state;
  logic [3:0]    tb_state;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] cons_cnt;
  logic          pending;
  logic [63:0]   lifo;
  logic [6:0]    sp;
  logic [5:0]    top_idx;
  logic [15:0]   dec_word;
  logic          dec_bit;
  logic [3:0]    nxt_state;
  logic          rd_issue;
  logic          unused_hi;

  assign rd_issue   = (state == TRACE) && !mem_stall_i;
  assign rd_en_o    = rd_issue;
  assign busy_o     = (state != IDLE);
  assign dout_vld_o = (state == OUT);
  assign top_idx    = 6'(sp - 7'd1);
  assign dout_o     = dout_vld_o & lifo[top_idx];
  assign dec_word   = rdata_i[15:0];
  assign unused_hi  = ^rdata_i[23:16];
  assign dec_bit    = tb_state[3];
  assign nxt_state  = {tb_state[2:0], dec_word[tb_state]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      tb_state <= 4'd0;
      rd_cnt   <= '0;
      cons_cnt <= '0;
      pending  <= 1'b0;
      sp       <= 7'd0;
      addr_o   <= 12'd0;
      done_o   <= 1'b0;
    end else begin
      done_o  <= 1'b0;
      pending <= rd_issue;
      // Pushes only happen while reads are in flight, pops only in OUT, so sp never sees both.
      if (pending) begin
        tb_state <= nxt_state;
        cons_cnt <= cons_cnt + 1'b1;
        if (cons_cnt >= DEPTH_C) begin
          lifo[sp[5:0]] <= dec_bit;
          sp            <= sp + 7'd1;
        end
      end
      case (state)
        IDLE: begin
          if (start_i) begin
            tb_state <= start_state_i;
            addr_o   <= end_addr_i;
            rd_cnt   <= '0;
            cons_cnt <= '0;
            sp       <= 7'd0;
            state    <= TRACE;
          end
        end
        TRACE: begin
          if (rd_issue) begin
            rd_cnt <= rd_cnt + 1'b1;
            // Keep the final issued address on addr_o after the last read.
            if (rd_cnt == LAST_RD) state <= DRAIN;
            else                   addr_o <= addr_o - 12'd1;
          end
        end
        DRAIN: begin
          if (pending) state <= OUT;
        end
        OUT: begin
          if (dout_rdy_i) begin
            sp <= sp - 7'd1;
            if (sp == 7'd1) begin
              state  <= IDLE;
              done_o <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VTB_FINAL_STATE_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      final_state_o <= 4'd0;
      final_vld_o   <= 1'b0;
    end else begin
      final_vld_o <= 1'b0;
      if (state == DRAIN && pending) begin
        final_state_o <= nxt_state;
        final_vld_o   <= 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
